// File: rtl/led_matrix_scan_ctrl_pkg.sv
// Shared definitions for the LED line scanner: scan FSM states, a clog2
// helper that never returns less than one bit, and a parameter sanity check.
package led_line_pkg;

  // Scan FSM states. IDLE keeps every output low, BLANK is the all-off
  // gap in front of each line, and DRIVE puts one line on the shared bus.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  // Returns ceil(log2(value)). The result is never below 1, so a counter
  // that only ever needs to hold 0 still gets a legal one-bit vector.
  function automatic int safe_clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << bits) < value) begin
        bits = bits + 1;
      end
    end
    return (bits < 1) ? 1 : bits;
  endfunction

  // True when the parameter set describes a buildable scanner: at least one
  // LED and one line, a non-empty blanking gap, and a dwell long enough to
  // hold at least one full PWM period.
  function automatic bit params_ok(input int leds, input int lines,
                                   input int dwell, input int blank,
                                   input int pwm_bits);
    return (leds >= 1) && (lines >= 1) && (blank >= 1) &&
           (pwm_bits >= 1) && (pwm_bits <= 30) &&
           (dwell >= (1 << pwm_bits));
  endfunction

endpackage

// File: rtl/led_matrix_scan_ctrl_if.sv
// Bundle of application-side inputs and matrix-side outputs of the scanner.
// The master drives the application inputs and watches the pins; the slave
// (the scanner) does the opposite. fsm_state mirrors the scan FSM for
// observation only and has no functional consumer.
//
// Handshake: there is no valid/ready pair on this bus. led_data and
// brightness are level inputs that are sampled only at frame snapshots;
// en is an asynchronous level that the scanner synchronises internally.
interface led_matrix_scan_ctrl_if
  import led_line_pkg::*;
#(
  parameter int P_NUMBER_LEDS  = 8,
  parameter int P_NUMBER_LINES = 3,
  parameter int P_PWM_BITS     = 4
);

  logic                                  en;
  logic [P_NUMBER_LINES*P_NUMBER_LEDS-1:0] led_data;
  logic [P_PWM_BITS-1:0]                 brightness;
  logic [P_NUMBER_LEDS-1:0]              LED_LINE_DATA;
  logic [P_NUMBER_LINES-1:0]             LED_LINE_EN;
  logic                                  frame_start;
  state_e                                fsm_state;

  modport master (
    output en,
    output led_data,
    output brightness,
    input  LED_LINE_DATA,
    input  LED_LINE_EN,
    input  frame_start,
    input  fsm_state
  );

  modport slave (
    input  en,
    input  led_data,
    input  brightness,
    output LED_LINE_DATA,
    output LED_LINE_EN,
    output frame_start,
    output fsm_state
  );

endinterface

// File: rtl/led_matrix_scan_ctrl_cdc_sync_bit.sv
// Two-flop synchroniser for a single asynchronous level into the aclk
// domain. Both flops clear on reset so the synchronised level starts low.
module cdc_sync_bit (
  input  logic aclk,
  input  logic aresetn,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw level through two flops to settle metastability.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Time-multiplexed LED line scanner. Each line gets an all-off blanking gap
// followed by a dwell period during which its snapshot data sits on the
// shared bus and its enable is gated by a global PWM duty. Line data and
// brightness are snapshotted once per frame so mid-frame writes never tear.
module led_matrix_scan_ctrl
  import led_line_pkg::*;
#(
  parameter int P_NUMBER_LEDS  = 8,
  parameter int P_NUMBER_LINES = 3,
  parameter int P_DWELL_CYCLES = 20000,
  parameter int P_BLANK_CYCLES = 20,
  parameter int P_PWM_BITS     = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  led_matrix_scan_ctrl_if.slave bus
);

  localparam int PHASE_MAX = (P_DWELL_CYCLES > P_BLANK_CYCLES) ?
                             P_DWELL_CYCLES : P_BLANK_CYCLES;
  localparam int PHASE_W   = safe_clog2(PHASE_MAX);
  localparam int LINE_W    = safe_clog2(P_NUMBER_LINES);
  localparam int DATA_W    = P_NUMBER_LINES * P_NUMBER_LEDS;

  localparam logic [PHASE_W-1:0] BLANK_LAST = PHASE_W'(P_BLANK_CYCLES - 1);
  localparam logic [PHASE_W-1:0] DWELL_LAST = PHASE_W'(P_DWELL_CYCLES - 1);
  localparam logic [LINE_W-1:0]  LINE_LAST  = LINE_W'(P_NUMBER_LINES - 1);

  // Reject parameter sets that cannot produce a sensible scan.
  if (!params_ok(P_NUMBER_LEDS, P_NUMBER_LINES, P_DWELL_CYCLES,
                 P_BLANK_CYCLES, P_PWM_BITS)) begin : g_param_check
    $error("led_matrix_scan_ctrl: illegal parameter combination");
  end

  logic                      en_s;
  state_e                    state;
  logic [PHASE_W-1:0]        phase;
  logic [LINE_W-1:0]         line_idx;
  logic [P_PWM_BITS-1:0]     pwm_cnt;
  logic [P_PWM_BITS-1:0]     pwm_inc;
  logic [DATA_W-1:0]         snap_data;
  logic [P_PWM_BITS-1:0]     snap_bright;
  logic [P_NUMBER_LEDS-1:0]  cur_line_data;
  logic [P_NUMBER_LINES-1:0] line_onehot;
  logic [P_NUMBER_LEDS-1:0]  line_data_q;
  logic [P_NUMBER_LINES-1:0] line_en_q;
  logic                      frame_start_q;

  cdc_sync_bit u_en_sync (
    .aclk    (aclk),
    .aresetn (aresetn),
    .d       (bus.en),
    .q       (en_s)
  );

  // Current line's snapshot slice, its one-hot enable and the PWM count
  // that the next cycle will carry.
  always_comb begin
    cur_line_data = snap_data[int'(line_idx)*P_NUMBER_LEDS +: P_NUMBER_LEDS];
    line_onehot   = P_NUMBER_LINES'(1) << line_idx;
    pwm_inc       = pwm_cnt + 1'b1;
  end

  // Scan FSM with registered outputs. Outputs are computed for the cycle
  // that follows each edge, so the enable uses the incremented PWM count.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      phase         <= '0;
      line_idx      <= '0;
      pwm_cnt       <= '0;
      snap_data     <= '0;
      snap_bright   <= '0;
      line_data_q   <= '0;
      line_en_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      pwm_cnt       <= pwm_inc;
      if (!en_s) begin
        // Losing enable abandons the current line wherever it was.
        state       <= IDLE;
        phase       <= '0;
        line_idx    <= '0;
        line_data_q <= '0;
        line_en_q   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state         <= BLANK;
            phase         <= '0;
            line_idx      <= '0;
            snap_data     <= bus.led_data;
            snap_bright   <= bus.brightness;
            frame_start_q <= 1'b1;
            line_data_q   <= '0;
            line_en_q     <= '0;
          end
          BLANK: begin
            line_data_q <= '0;
            line_en_q   <= '0;
            if (phase == BLANK_LAST) begin
              state       <= DRIVE;
              phase       <= '0;
              pwm_cnt     <= '0;
              line_data_q <= cur_line_data;
              line_en_q   <= (snap_bright != '0) ? line_onehot : '0;
            end else begin
              phase <= phase + 1'b1;
            end
          end
          DRIVE: begin
            if (phase == DWELL_LAST) begin
              state       <= BLANK;
              phase       <= '0;
              line_data_q <= '0;
              line_en_q   <= '0;
              if (line_idx == LINE_LAST) begin
                // Frame boundary: wrap to line 0 and take a fresh snapshot.
                line_idx      <= '0;
                snap_data     <= bus.led_data;
                snap_bright   <= bus.brightness;
                frame_start_q <= 1'b1;
              end else begin
                line_idx <= line_idx + 1'b1;
              end
            end else begin
              phase     <= phase + 1'b1;
              line_en_q <= (pwm_inc < snap_bright) ? line_onehot : '0;
            end
          end
          default: begin
            state       <= IDLE;
            phase       <= '0;
            line_idx    <= '0;
            line_data_q <= '0;
            line_en_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.LED_LINE_DATA = line_data_q;
  assign bus.LED_LINE_EN   = line_en_q;
  assign bus.frame_start   = frame_start_q;
  assign bus.fsm_state     = state;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Bench for led_matrix_scan_ctrl with LEDS=8, LINES=3, DWELL=32, BLANK=2,
// PWM_BITS=4. Expected pin words {frame_start, LED_LINE_EN, LED_LINE_DATA}
// are generated cycle by cycle from the scan description and queued, then
// popped against the DUT on falling edges.
module tb_led_matrix_scan_ctrl;
  import led_line_pkg::*;

  localparam int LEDS  = 8;
  localparam int LINES = 3;
  localparam int DWELL = 32;
  localparam int BLANK_C = 2;
  localparam int PWMB  = 4;
  localparam int W     = 1 + LINES + LEDS;
  localparam int FRAME = LINES * (DWELL + BLANK_C);

  logic aclk;
  logic aresetn;
  int   checks;
  int   errors;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  logic [W-1:0] act_w;

  led_matrix_scan_ctrl_if #(
    .P_NUMBER_LEDS  (LEDS),
    .P_NUMBER_LINES (LINES),
    .P_PWM_BITS     (PWMB)
  ) bus ();

  led_matrix_scan_ctrl #(
    .P_NUMBER_LEDS  (LEDS),
    .P_NUMBER_LINES (LINES),
    .P_DWELL_CYCLES (DWELL),
    .P_BLANK_CYCLES (BLANK_C),
    .P_PWM_BITS     (PWMB)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  // Clock and reset defaults.
  initial aclk = 1'b0;
  always #25 aclk = ~aclk;

  function automatic logic [W-1:0] out_word();
    return {bus.frame_start, bus.LED_LINE_EN, bus.LED_LINE_DATA};
  endfunction

  // Reference model: one frame of pin words starting at the frame_start cycle.
  task automatic push_frame(input logic [LINES*LEDS-1:0] data, input logic [PWMB-1:0] bright);
    logic [W-1:0] w;
    for (int k = 0; k < LINES; k++) begin
      for (int b = 0; b < BLANK_C; b++) begin
        w = '0;
        w[W-1] = (k == 0 && b == 0);
        exp_q.push_back(w);
      end
      for (int d = 0; d < DWELL; d++) begin
        w = '0;
        w[LEDS-1:0] = data[k*LEDS +: LEDS];
        if ((d % (1 << PWMB)) < int'(bright)) w[LEDS + k] = 1'b1;
        exp_q.push_back(w);
      end
    end
  endtask

  // Driver: park in IDLE, load inputs, raise en and return the number of
  // rising edges until frame_start is seen (-1 if it never arrives).
  task automatic start_scan(input logic [LINES*LEDS-1:0] data, input logic [PWMB-1:0] bright,
                            output int lat);
    bus.en = 1'b0;
    repeat (4) @(negedge aclk);
    bus.led_data   = data;
    bus.brightness = bright;
    bus.en         = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge aclk);
      @(negedge aclk);
      if (bus.frame_start === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    aresetn = 1'b0;
    bus.en = 1'b1;
    bus.led_data = 24'h332211;
    bus.brightness = 4'd15;
    repeat (5) @(negedge aclk);
    checks++;
    if (out_word() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", out_word(), {W{1'b0}});
    end
    checks++;
    if (bus.fsm_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", bus.fsm_state, IDLE);
    end
    aresetn = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge aclk);
      @(negedge aclk);
      if (bus.frame_start === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL reset_release_latency: got %0d expected 3", lat);
    end
  endtask

  task automatic test_scan_order();
    int lat;
    start_scan(24'h332211, 4'd15, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL scan_en_latency: got %0d expected 3", lat);
    end
    exp_q.delete();
    push_frame(24'h332211, 4'd15);
    push_frame(24'h332211, 4'd15);
    for (int c = 0; c < 2 * FRAME; c++) begin
      exp_w = exp_q.pop_front();
      act_w = out_word();
      checks++;
      if (act_w !== exp_w) begin
        errors++;
        $display("FAIL scan_order cycle %0d: got %h expected %h", c, act_w, exp_w);
      end
      @(negedge aclk);
    end
    // Third frame must begin exactly one frame period later.
    checks++;
    if (bus.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL scan_frame_period: got frame_start=%b expected 1", bus.frame_start);
    end
  endtask

  task automatic test_pwm();
    int lat;
    int en_cnt;
    for (int t = 0; t < 2; t++) begin
      logic [PWMB-1:0] bright;
      bright = (t == 0) ? 4'd4 : 4'd0;
      start_scan(24'hA5_5A_C3, bright, lat);
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL pwm_en_latency: got %0d expected 3", lat);
      end
      exp_q.delete();
      push_frame(24'hA5_5A_C3, bright);
      en_cnt = 0;
      for (int c = 0; c < FRAME; c++) begin
        exp_w = exp_q.pop_front();
        act_w = out_word();
        if (bus.LED_LINE_EN !== '0) en_cnt++;
        checks++;
        if (act_w !== exp_w) begin
          errors++;
          $display("FAIL pwm_b%0d cycle %0d: got %h expected %h", bright, c, act_w, exp_w);
        end
        @(negedge aclk);
      end
      checks++;
      if (en_cnt !== LINES * ((DWELL / (1 << PWMB)) * int'(bright))) begin
        errors++;
        $display("FAIL pwm_on_count_b%0d: got %0d expected %0d", bright, en_cnt,
                 LINES * ((DWELL / (1 << PWMB)) * int'(bright)));
      end
    end
  endtask

  task automatic test_snapshot();
    int lat;
    start_scan(24'h332211, 4'd15, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL snap_en_latency: got %0d expected 3", lat);
    end
    exp_q.delete();
    push_frame(24'h332211, 4'd15);
    push_frame(24'hFFFFFF, 4'd15);
    for (int c = 0; c < 2 * FRAME; c++) begin
      exp_w = exp_q.pop_front();
      act_w = out_word();
      checks++;
      if (act_w !== exp_w) begin
        errors++;
        $display("FAIL snapshot cycle %0d: got %h expected %h", c, act_w, exp_w);
      end
      // Rewrite the pattern while line 1 is on the bus.
      if (c == (DWELL + BLANK_C) + BLANK_C + 5) bus.led_data = 24'hFFFFFF;
      @(negedge aclk);
    end
  endtask

  task automatic test_disable();
    int lat;
    start_scan(24'h332211, 4'd15, lat);
    exp_q.delete();
    push_frame(24'h332211, 4'd15);
    for (int c = 0; c <= (DWELL + BLANK_C) + BLANK_C + 10; c++) begin
      exp_w = exp_q.pop_front();
      act_w = out_word();
      checks++;
      if (act_w !== exp_w) begin
        errors++;
        $display("FAIL disable_pre cycle %0d: got %h expected %h", c, act_w, exp_w);
      end
      @(negedge aclk);
    end
    bus.en = 1'b0;
    repeat (3) begin
      @(posedge aclk);
      @(negedge aclk);
    end
    checks++;
    if (out_word() !== '0 || bus.fsm_state !== IDLE) begin
      errors++;
      $display("FAIL disable_outputs: got %h state %0d expected %h state %0d",
               out_word(), bus.fsm_state, {W{1'b0}}, IDLE);
    end
    exp_q.delete();
    start_scan(24'h665544, 4'd15, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL reenable_latency: got %0d expected 3", lat);
    end
    push_frame(24'h665544, 4'd15);
    for (int c = 0; c < FRAME; c++) begin
      exp_w = exp_q.pop_front();
      act_w = out_word();
      checks++;
      if (act_w !== exp_w) begin
        errors++;
        $display("FAIL reenable cycle %0d: got %h expected %h", c, act_w, exp_w);
      end
      @(negedge aclk);
    end
  endtask

  task automatic test_reset_mid_drive();
    int lat;
    start_scan(24'h332211, 4'd15, lat);
    exp_q.delete();
    push_frame(24'h332211, 4'd15);
    for (int c = 0; c < BLANK_C + 8; c++) begin
      exp_w = exp_q.pop_front();
      act_w = out_word();
      checks++;
      if (act_w !== exp_w) begin
        errors++;
        $display("FAIL rst_mid_pre cycle %0d: got %h expected %h", c, act_w, exp_w);
      end
      @(negedge aclk);
    end
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (out_word() !== '0 || bus.fsm_state !== IDLE) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h state %0d expected %h state %0d",
               out_word(), bus.fsm_state, {W{1'b0}}, IDLE);
    end
    aresetn = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge aclk);
      @(negedge aclk);
      if (bus.frame_start === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL rst_mid_restart_latency: got %0d expected 3", lat);
    end
    exp_q.delete();
    push_frame(24'h332211, 4'd15);
    for (int c = 0; c < FRAME; c++) begin
      exp_w = exp_q.pop_front();
      act_w = out_word();
      checks++;
      if (act_w !== exp_w) begin
        errors++;
        $display("FAIL rst_mid_restart cycle %0d: got %h expected %h", c, act_w, exp_w);
      end
      @(negedge aclk);
    end
  endtask

  // Test sequence and final report.
  initial begin
    checks = 0;
    errors = 0;
    aresetn = 1'b0;
    bus.en = 1'b0;
    bus.led_data = '0;
    bus.brightness = '0;
    @(negedge aclk);
    test_reset();
    test_scan_order();
    test_pwm();
    test_snapshot();
    test_disable();
    test_reset_mid_drive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
